// File: rtl/xoro_bus_pkg.sv
// Shared bus-response definitions: FSM state encoding, default sizing, device indices.
package xoro_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int          NUM_DEVS_DEF   = 8;
    localparam logic [31:0] ERROR_DATA_DEF = 32'hDEADBEEF;

    localparam int DEV_0   = 0;
    localparam int DEV_1   = 1;
    localparam int DEV_2   = 2;
    localparam int DEV_3   = 3;
    localparam int DEV_4   = 4;
    localparam int DEV_5   = 5;
    localparam int DEV_6   = 6;
    localparam int DEV_RAM = 7;

endpackage

// File: rtl/onehot_to_index.sv
// One-hot to binary index encoder; valid is high only when exactly one bit is set.
module onehot_to_index #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    always_comb begin
        index = '0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                index = index | IDX_W'(i);
            end
        end
        valid = $onehot(onehot);
    end

endmodule

// File: rtl/bus_response_mux.sv
// Returns one registered response per CPU request from the device selected at request start.
// Optional BUS_TIMEOUT_EN: a stalled WAIT forces an error response after TIMEOUT_CYCLES.
module bus_response_mux
    import xoro_bus_pkg::*;
#(
    parameter int                 NUM_DEVS       = NUM_DEVS_DEF,
    parameter int                 DATA_W         = 32,
    parameter int                 TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0]  ERROR_DATA     = DATA_W'(ERROR_DATA_DEF)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_valid,
    input  logic [NUM_DEVS-1:0]        enables,
    input  logic [NUM_DEVS-1:0]        dev_ready,
    input  logic [NUM_DEVS*DATA_W-1:0] dev_rdata,
    output logic                       mem_ready,
    output logic [DATA_W-1:0]          mem_rdata,
    output logic                       bus_error
);

    localparam int IDX_W = $clog2(NUM_DEVS);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] RESP = ST_RESP;

    logic [1:0]        state;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  req_idx;
    logic              req_onehot;
    logic [DATA_W-1:0] sel_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] count;
`endif

    onehot_to_index #(
        .N     (NUM_DEVS),
        .IDX_W (IDX_W)
    ) u_enc (
        .onehot (enables),
        .index  (req_idx),
        .valid  (req_onehot)
    );

    assign sel_rdata = dev_rdata[sel*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            bus_error <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            count     <= '0;
`endif
        end else begin
            // Completion flags are pulses: only the cycle spent in RESP carries them.
            mem_ready <= 1'b0;
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        sel <= req_idx;
                        if (req_onehot) begin
                            state <= WAIT;
`ifdef BUS_TIMEOUT_EN
                            count <= '0;
`endif
                        end else begin
                            state     <= RESP;
                            mem_ready <= 1'b1;
                            bus_error <= 1'b1;
                            mem_rdata <= ERROR_DATA;
                        end
                    end
                end
                WAIT: begin
                    if (!mem_valid) begin
                        state <= IDLE;
                    end else if (dev_ready[sel]) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                        mem_rdata <= sel_rdata;
                    end
`ifdef BUS_TIMEOUT_EN
                    // Ready is checked first so a response on the final cycle still wins.
                    else if (count == CNT_MAX) begin
                        state     <= RESP;
                        mem_ready <= 1'b1;
                        bus_error <= 1'b1;
                        mem_rdata <= ERROR_DATA;
                    end else begin
                        count <= count + 1'b1;
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_response_mux.sv
// Randomized and directed checks of bus_response_mux against a latency/data reference model.
module tb_bus_response_mux;

    localparam int          N     = 8;
    localparam int          DW    = 32;
    localparam int          T     = 4;
    localparam logic [31:0] ERR   = 32'hDEADBEEF;
    localparam int          NEVER = 1000000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            mem_valid = 1'b0;
    logic [N-1:0]    enables = '0;
    logic [N-1:0]    dev_ready = '0;
    logic [N*DW-1:0] dev_rdata = '0;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;
    logic            bus_error;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_rdata = '0;

    bus_response_mux #(
        .NUM_DEVS       (N),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (T),
        .ERROR_DATA     (ERR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .enables   (enables),
        .dev_ready (dev_ready),
        .dev_rdata (dev_rdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .bus_error (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive device-side inputs: noise on every device except the selected one.
    task automatic drive_devs(input bit has_sel, input int idx, input logic rdy, input logic [31:0] data);
        for (int i = 0; i < N; i++) begin
            dev_rdata[i*DW +: DW] = $urandom;
            dev_ready[i]          = 1'($urandom_range(0, 1));
        end
        if (has_sel) begin
            dev_rdata[idx*DW +: DW] = data;
            dev_ready[idx]          = rdy;
        end
    endtask

    // One request issued at a negedge; selected ready rises after r rising edges.
    task automatic run_req(input string tag, input logic [N-1:0] en, input int r,
                           input logic [31:0] data, input int budget);
        int          idx = 0;
        bit          good;
        int          exp_lat;
        bit          exp_err;
        bit          got = 0;
        int          lat = 0;
        logic [31:0] obs_data = '0;
        logic        obs_err = 1'b0;

        good = ($countones(en) == 1);
        for (int i = 0; i < N; i++) if (en[i]) idx = i;

        if (!good) begin
            exp_lat = 1;
            exp_err = 1'b1;
        end else begin
            exp_lat = (r + 1 > 2) ? r + 1 : 2;
            exp_err = 1'b0;
`ifdef BUS_TIMEOUT_EN
            if (exp_lat > T + 2) begin
                exp_lat = T + 2;
                exp_err = 1'b1;
            end
`endif
        end

        mem_valid = 1'b1;
        enables   = en;
        drive_devs(good, idx, (r == 0), data);
        for (int n = 1; n <= budget && !got; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                got      = 1;
                lat      = n;
                obs_data = mem_rdata;
                obs_err  = bus_error;
            end else begin
                enables = N'($urandom);
                drive_devs(good, idx, (n >= r), data);
            end
        end
        mem_valid = 1'b0;
        enables   = '0;
        dev_ready = '0;

        chk({tag, ".responded"}, 32'(got), 32'(exp_lat <= budget));
        if (exp_lat <= budget && got) begin
            chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
            chk({tag, ".rdata"}, obs_data, exp_err ? ERR : data);
            chk({tag, ".bus_error"}, 32'(obs_err), 32'(exp_err));
            last_rdata = exp_err ? ERR : data;
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".ready_low_after"}, 32'(mem_ready), 32'd0);
        chk({tag, ".error_low_after"}, 32'(bus_error), 32'd0);
        chk({tag, ".rdata_held"}, mem_rdata, last_rdata);
    endtask

    initial begin
        #3;
        chk("reset.mem_ready", 32'(mem_ready), 32'd0);
        chk("reset.mem_rdata", mem_rdata, 32'd0);
        chk("reset.bus_error", 32'(bus_error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_req("t1_dev2", 8'h04, 3, 32'h12345678, 20);
        run_req("t2_ram", 8'h80, 0, 32'hCAFEF00D, 20);
        run_req("t3_zero_en", 8'h00, 0, 32'h0, 20);
        run_req("t3_multi_en", 8'h03, 0, 32'h0, 20);

`ifdef BUS_TIMEOUT_EN
        run_req("t4_timeout", 8'h08, NEVER, 32'h0, 20);
        run_req("t4_ready_on_last", 8'h08, T + 1, 32'h0BADF00D, 20);
`else
        run_req("t4_no_timeout", 8'h08, NEVER, 32'h0, 1000);
`endif

        run_req("t5_abort", 8'h10, NEVER, 32'h0, 3);
        run_req("t5_dev1", 8'h02, 1, 32'hA5A55A5A, 20);

        // Reset while RESP is presenting an error response.
        enables   = 8'h00;
        mem_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_resp.mem_ready_before", 32'(mem_ready), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_resp.mem_ready", 32'(mem_ready), 32'd0);
        chk("t6_resp.bus_error", 32'(bus_error), 32'd0);
        chk("t6_resp.mem_rdata", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_rdata = '0;
        run_req("t6_refill", 8'h20, 2, 32'h13572468, 20);

        // Reset while stalled in WAIT.
        enables   = 8'h40;
        mem_valid = 1'b1;
        dev_ready = '0;
        repeat (3) @(negedge clk);
        chk("t6_wait.no_ready", 32'(mem_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_wait.mem_ready", 32'(mem_ready), 32'd0);
        chk("t6_wait.bus_error", 32'(bus_error), 32'd0);
        chk("t6_wait.mem_rdata", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_rdata = '0;
        run_req("t6_post_reset", 8'h40, 2, 32'h2468ACE0, 20);

        for (int k = 0; k < 30; k++) begin
            logic [N-1:0] en;
            int           pick;
            pick = $urandom_range(0, 9);
            if (pick == 0)      en = '0;
            else if (pick == 1) en = N'($urandom) | 8'h81;
            else                en = N'(1) << $urandom_range(0, N - 1);
            run_req($sformatf("rand%0d", k), en, $urandom_range(0, 8), $urandom, 20);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
